// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side pointer controller of the UART asynchronous FIFO. Lives entirely
// in the read clock domain: owns the binary read pointer, the memory read
// address and the registered Gray read pointer that is handed to the write
// domain synchroniser. Status flags (EMPTY, ALMOST_EMPTY, rd_count) are
// derived from the write pointer, which arrives already synchronised.
// UNDERFLOW is a sticky error that records a read attempted while empty.
// -----------------------------------------------------------------------------
module fifo_rd_ctrl #(
    parameter int PTR_WD   = 4,
    parameter int AE_LEVEL = 2
) (
    input  logic              R_CLK,
    input  logic              R_RST,
    input  logic              R_INC,
    input  logic              ERR_CLR,
    input  logic [PTR_WD-1:0] w2r_ptr,
    output logic [PTR_WD-1:0] gray_rd_ptr,
    output logic [PTR_WD-2:0] rd_addr,
    output logic              EMPTY,
    output logic              ALMOST_EMPTY,
    output logic [PTR_WD-1:0] rd_count,
    output logic              UNDERFLOW
);

    // Threshold expressed at pointer width so the compare is width-matched.
    localparam logic [PTR_WD-1:0] AE_LVL_C = PTR_WD'(AE_LEVEL);
    localparam logic [PTR_WD-1:0] ONE_C    = PTR_WD'(1);

    // Binary to Gray: adjacent codes differ in exactly one bit, which is what
    // makes the pointer safe to sample in the other clock domain.
    function automatic logic [PTR_WD-1:0] bin2gray(input logic [PTR_WD-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary, iterative from the MSB down: each binary bit is the
    // running XOR of all Gray bits at or above it.
    function automatic logic [PTR_WD-1:0] gray2bin(input logic [PTR_WD-1:0] g);
        logic [PTR_WD-1:0] b;
        b             = '0;
        b[PTR_WD-1]   = g[PTR_WD-1];
        for (int i = PTR_WD - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // State
    logic [PTR_WD-1:0] rd_ptr_q;
    logic [PTR_WD-1:0] rd_ptr_d;
    logic [PTR_WD-1:0] gray_rd_ptr_q;
    logic [PTR_WD-1:0] gray_rd_ptr_d;
    logic              underflow_q;
    logic              underflow_d;

    // Combinational helpers
    logic              empty_s;
    logic              pop_s;
    logic              underflow_set_s;
    logic [PTR_WD-1:0] w_bin_s;
    logic [PTR_WD-1:0] rd_count_s;

    // Status decode: empty when the two Gray pointers match, occupancy from
    // the binary difference (intentionally not clamped so a protocol
    // violation remains visible).
    always_comb begin
        empty_s    = (gray_rd_ptr_q == w2r_ptr);
        w_bin_s    = gray2bin(w2r_ptr);
        rd_count_s = w_bin_s - rd_ptr_q;
    end

    // Next-state logic for the pointers and the sticky underflow flag.
    always_comb begin
        pop_s           = 1'b0;
        underflow_set_s = 1'b0;
        rd_ptr_d        = rd_ptr_q;
        gray_rd_ptr_d   = gray_rd_ptr_q;
        underflow_d     = underflow_q;

        if (R_INC && !empty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end

        if (R_INC && empty_s) begin
            underflow_set_s = 1'b1;
        end else begin
            underflow_set_s = 1'b0;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + ONE_C;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // Gray pointer is computed from the next binary value so that it is
        // updated on the same edge as rd_ptr with no skew between them.
        gray_rd_ptr_d = bin2gray(rd_ptr_d);

        // Set has priority over clear so a simultaneous error is never lost.
        if (underflow_set_s) begin
            underflow_d = 1'b1;
        end else if (ERR_CLR) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // State registers with synchronous reset overriding all other inputs.
    always_ff @(posedge R_CLK) begin
        if (R_RST) begin
            rd_ptr_q      <= '0;
            gray_rd_ptr_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            gray_rd_ptr_q <= gray_rd_ptr_d;
            underflow_q   <= underflow_d;
        end
    end

    // Output mapping; memory address is the pointer without its wrap bit.
    always_comb begin
        gray_rd_ptr  = gray_rd_ptr_q;
        rd_addr      = rd_ptr_q[PTR_WD-2:0];
        EMPTY        = empty_s;
        rd_count     = rd_count_s;
        ALMOST_EMPTY = (rd_count_s <= AE_LVL_C);
        UNDERFLOW    = underflow_q;
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
// Self-checking bench for fifo_rd_ctrl (PTR_WD=4, AE_LEVEL=2). A reference
// model predicts the post-edge outputs of every driven cycle and pushes them
// into a scoreboard queue; each test task pops and compares after the edge.
// Known values from the test plan are also checked as constants.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

    localparam int PTR_WD   = 4;
    localparam int AE_LEVEL = 2;

    logic              R_CLK;
    logic              R_RST;
    logic              R_INC;
    logic              ERR_CLR;
    logic [PTR_WD-1:0] w2r_ptr;
    logic [PTR_WD-1:0] gray_rd_ptr;
    logic [PTR_WD-2:0] rd_addr;
    logic              EMPTY;
    logic              ALMOST_EMPTY;
    logic [PTR_WD-1:0] rd_count;
    logic              UNDERFLOW;

    fifo_rd_ctrl #(.PTR_WD(PTR_WD), .AE_LEVEL(AE_LEVEL)) dut (
        .R_CLK       (R_CLK),
        .R_RST       (R_RST),
        .R_INC       (R_INC),
        .ERR_CLR     (ERR_CLR),
        .w2r_ptr     (w2r_ptr),
        .gray_rd_ptr (gray_rd_ptr),
        .rd_addr     (rd_addr),
        .EMPTY       (EMPTY),
        .ALMOST_EMPTY(ALMOST_EMPTY),
        .rd_count    (rd_count),
        .UNDERFLOW   (UNDERFLOW)
    );

    initial R_CLK = 1'b0;
    always #5 R_CLK = ~R_CLK;

    typedef struct packed {
        logic [3:0] gray;
        logic [2:0] addr;
        logic       empty;
        logic       ae;
        logic [3:0] cnt;
        logic       uf;
    } obs_t;

    obs_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    logic [3:0] m_ptr = 4'd0;
    logic       m_uf  = 1'b0;

    function automatic logic [3:0] m_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] m_bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    function automatic obs_t m_outputs(input logic [3:0] p, input logic u, input logic [3:0] w);
        obs_t o;
        o.gray  = m_gray(p);
        o.addr  = p[2:0];
        o.empty = (m_gray(p) == w);
        o.cnt   = m_bin(w) - p;
        o.ae    = (o.cnt <= 4'd2);
        o.uf    = u;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.gray  = gray_rd_ptr;
        o.addr  = rd_addr;
        o.empty = EMPTY;
        o.ae    = ALMOST_EMPTY;
        o.cnt   = rd_count;
        o.uf    = UNDERFLOW;
        return o;
    endfunction

    // Drive one cycle, advance the model, push its prediction, then wait
    // until just after the edge so the caller can pop and compare.
    task automatic drive_cycle(input logic rst, input logic inc, input logic clr, input logic [3:0] w);
        logic empty_now;
        @(negedge R_CLK);
        R_RST = rst; R_INC = inc; ERR_CLR = clr; w2r_ptr = w;
        empty_now = (m_gray(m_ptr) == w);
        if (rst) begin
            m_ptr = 4'd0;
            m_uf  = 1'b0;
        end else begin
            if (inc && empty_now) m_uf = 1'b1;
            else if (clr)         m_uf = 1'b0;
            if (inc && !empty_now) m_ptr = m_ptr + 4'd1;
        end
        sb_q.push_back(m_outputs(m_ptr, m_uf, w));
        @(posedge R_CLK);
        #1;
        R_RST = 1'b0; R_INC = 1'b0; ERR_CLR = 1'b0;
    endtask

    task automatic test_reset();
        obs_t exp, obs;
        drive_cycle(1'b1, 1'b1, 1'b0, 4'b0000);
        exp = sb_q.pop_front(); obs = sample(); checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_sb got=%h exp=%h", obs, exp);
        end
        checks++;
        if (obs !== {4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_const got=%h exp=%h", obs, {4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0});
        end
    endtask

    task automatic test_fill_drain();
        obs_t exp, obs;
        logic [3:0] gseq [5] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
        logic [3:0] cseq [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        @(negedge R_CLK);
        w2r_ptr = 4'b0111;
        #1;
        checks++;
        if (rd_count !== 4'd5 || EMPTY !== 1'b0 || ALMOST_EMPTY !== 1'b0) begin
            errors++;
            $display("FAIL fill_start got cnt=%0d e=%b ae=%b exp cnt=5 e=0 ae=0", rd_count, EMPTY, ALMOST_EMPTY);
        end
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 4'b0111);
            exp = sb_q.pop_front(); obs = sample(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL drain_sb[%0d] got=%h exp=%h", i, obs, exp);
            end
            checks++;
            if (gray_rd_ptr !== gseq[i] || rd_addr !== 3'(i + 1) || rd_count !== cseq[i] ||
                ALMOST_EMPTY !== (i >= 2) || EMPTY !== (i == 4)) begin
                errors++;
                $display("FAIL drain_const[%0d] got g=%b a=%0d c=%0d ae=%b e=%b exp g=%b a=%0d c=%0d",
                         i, gray_rd_ptr, rd_addr, rd_count, ALMOST_EMPTY, EMPTY, gseq[i], i + 1, cseq[i]);
            end
        end
    endtask

    task automatic test_underflow();
        obs_t exp, obs;
        // read attempt while empty: pointer holds, flag sets
        drive_cycle(1'b0, 1'b1, 1'b0, 4'b0111);
        exp = sb_q.pop_front(); obs = sample(); checks++;
        if (obs !== exp || rd_addr !== 3'd5 || UNDERFLOW !== 1'b1) begin
            errors++;
            $display("FAIL uf_set got=%h exp=%h", obs, exp);
        end
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 4'b0111);
            exp = sb_q.pop_front(); obs = sample(); checks++;
            if (obs !== exp || UNDERFLOW !== 1'b1) begin
                errors++;
                $display("FAIL uf_hold[%0d] got=%h exp=%h", i, obs, exp);
            end
        end
        drive_cycle(1'b0, 1'b1, 1'b1, 4'b0111);
        exp = sb_q.pop_front(); obs = sample(); checks++;
        if (obs !== exp || UNDERFLOW !== 1'b1) begin
            errors++;
            $display("FAIL uf_set_wins got=%h exp=%h", obs, exp);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, 4'b0111);
        exp = sb_q.pop_front(); obs = sample(); checks++;
        if (obs !== exp || UNDERFLOW !== 1'b0) begin
            errors++;
            $display("FAIL uf_clear got=%h exp=%h", obs, exp);
        end
    endtask

    task automatic test_wrap();
        obs_t exp, obs;
        logic [3:0] gseq [4] = '{4'b1000, 4'b0000, 4'b0001, 4'b0011};
        logic [2:0] aseq [4] = '{3'd7, 3'd0, 3'd1, 3'd2};
        drive_cycle(1'b1, 1'b0, 1'b0, 4'b1001);
        void'(sb_q.pop_front());
        // advance to rd_ptr=14 (write pointer parked at gray(14)=1001)
        for (int i = 0; i < 14; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 4'b1001);
            exp = sb_q.pop_front(); obs = sample(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL wrap_fill[%0d] got=%h exp=%h", i, obs, exp);
            end
        end
        @(negedge R_CLK);
        w2r_ptr = 4'b0011;
        #1;
        checks++;
        if (rd_count !== 4'd4 || rd_addr !== 3'd6 || EMPTY !== 1'b0) begin
            errors++;
            $display("FAIL wrap_count got cnt=%0d a=%0d e=%b exp cnt=4 a=6 e=0", rd_count, rd_addr, EMPTY);
        end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 4'b0011);
            exp = sb_q.pop_front(); obs = sample(); checks++;
            if (obs !== exp || gray_rd_ptr !== gseq[i] || rd_addr !== aseq[i] || EMPTY !== (i == 3)) begin
                errors++;
                $display("FAIL wrap_pop[%0d] got=%h exp=%h g_exp=%b", i, obs, exp, gseq[i]);
            end
        end
    endtask

    task automatic test_full_depth();
        obs_t exp, obs;
        drive_cycle(1'b1, 1'b0, 1'b0, 4'b1100);
        exp = sb_q.pop_front(); obs = sample(); checks++;
        if (obs !== exp || rd_count !== 4'd8 || EMPTY !== 1'b0 || ALMOST_EMPTY !== 1'b0) begin
            errors++;
            $display("FAIL full_depth got=%h exp=%h", obs, exp);
        end
    endtask

    task automatic test_mid_reset();
        obs_t exp, obs;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 4'b1100);
            exp = sb_q.pop_front(); obs = sample(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL mid_pop[%0d] got=%h exp=%h", i, obs, exp);
            end
        end
        checks++;
        if (rd_addr !== 3'd6 || rd_count !== 4'd2 || ALMOST_EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got a=%0d c=%0d ae=%b exp a=6 c=2 ae=1", rd_addr, rd_count, ALMOST_EMPTY);
        end
        drive_cycle(1'b1, 1'b1, 1'b0, 4'b1100);
        exp = sb_q.pop_front(); obs = sample(); checks++;
        if (obs !== exp || gray_rd_ptr !== 4'b0000 || rd_addr !== 3'd0 || UNDERFLOW !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got=%h exp=%h", obs, exp);
        end
    endtask

    task automatic test_concurrent_write();
        obs_t exp, obs;
        // pop while the write pointer advances 8 -> 9 (gray 1101)
        drive_cycle(1'b0, 1'b1, 1'b0, 4'b1101);
        exp = sb_q.pop_front(); obs = sample(); checks++;
        if (obs !== exp || rd_count !== 4'd8) begin
            errors++;
            $display("FAIL concurrent got=%h exp=%h", obs, exp);
        end
    endtask

    initial begin
        R_RST = 1'b0; R_INC = 1'b0; ERR_CLR = 1'b0; w2r_ptr = 4'b0000;
        test_reset();
        test_fill_drain();
        test_underflow();
        test_wrap();
        test_full_depth();
        test_mid_reset();
        test_concurrent_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side pointer controller for the UART system's asynchronous FIFO. It runs entirely in the read clock domain and owns the binary read pointer and the memory read address. It publishes a registered Gray-coded read pointer for synchronisation into the write domain. It derives EMPTY, occupancy, ALMOST_EMPTY and a sticky underflow flag from the write pointer, which arrives already synchronised into the read domain.

Parameters:
PTR_WD, 4, pointer width incl. wrap bit; FIFO depth = 2^(PTR_WD-1)
AE_LEVEL, 2, ALMOST_EMPTY threshold in entries (0 .. 2^(PTR_WD-1))

Ports:
R_CLK  input  1  read-domain clock, rising edge
R_RST  input  1  reset, synchronous, active-high
R_INC  input  1  read request; pops one entry when EMPTY=0
ERR_CLR  input  1  clears UNDERFLOW
w2r_ptr  input  PTR_WD  write Gray pointer, already synchronised to R_CLK
gray_rd_ptr  output  PTR_WD  registered Gray read pointer, to write-domain synchroniser
rd_addr  output  PTR_WD-1  memory read address
EMPTY  output  1  FIFO empty
ALMOST_EMPTY  output  1  occupancy <= AE_LEVEL
rd_count  output  PTR_WD  entries available (0 .. 2^(PTR_WD-1))
UNDERFLOW  output  1  sticky: a read was attempted while EMPTY

Behaviour:
- Reset (R_RST=1 at a rising R_CLK edge, which overrides all other inputs): rd_ptr=0, gray_rd_ptr=0, UNDERFLOW=0.
- Combinational outputs after reset: rd_addr=0. EMPTY = (w2r_ptr==0). rd_count = bin(w2r_ptr).
- Reset mid-operation discards the pointer state. The only state is rd_ptr, gray_rd_ptr and UNDERFLOW.
- rd_ptr is a binary PTR_WD-bit register.
- When R_INC=1 and EMPTY=0: rd_ptr <= rd_ptr+1, modulo 2^PTR_WD. Otherwise rd_ptr holds.
- rd_addr = rd_ptr[PTR_WD-2:0], combinational. Memory read data is valid in the same cycle.
- gray_rd_ptr is registered and updated on the same edge as rd_ptr.
  - It equals gray(rd_ptr_next), where gray(b) = b ^ (b>>1), parameterised and not a lookup table.
  - It therefore always equals gray(rd_ptr), with zero-cycle skew. Exactly one bit changes per increment, including the wrap from 2^PTR_WD-1 to 0.
- EMPTY = (gray_rd_ptr == w2r_ptr), combinational.
- rd_count = (bin(w2r_ptr) - rd_ptr) mod 2^PTR_WD, combinational.
  - bin() is the iterative Gray-to-binary conversion: b[MSB]=g[MSB]; b[i]=b[i+1]^g[i].
  - Maximum legal value is 2^(PTR_WD-1). Larger values indicate a protocol violation and are not clamped.
- ALMOST_EMPTY = (rd_count <= AE_LEVEL), combinational. EMPTY=1 implies ALMOST_EMPTY=1.
- UNDERFLOW:
  - Set on the edge where R_INC=1 and EMPTY=1.
  - Cleared on the edge where ERR_CLR=1.
  - If set and clear occur in the same cycle, set wins.
  - Otherwise it holds.
  - The pointer never moves on an underflow attempt.
- Read at the last entry: the pop occurs, and EMPTY asserts in the following cycle provided w2r_ptr is unchanged.
- w2r_ptr changing in the same cycle as a pop: both take effect, and rd_count reflects both in the next cycle.
- Latency: rd_addr and gray_rd_ptr advance 1 cycle after the accepted R_INC. Flags reflect each new pointer combinationally.

Test Plan:
- Reset, PTR_WD=4, AE_LEVEL=2, w2r_ptr=0000, R_INC=1 during reset -> gray_rd_ptr=0000, rd_addr=0, EMPTY=1, rd_count=0, ALMOST_EMPTY=1, UNDERFLOW=0.
- w2r_ptr=0111 (bin 5), R_INC=1 for 5 cycles:
  - gray_rd_ptr steps 0001,0011,0010,0110,0111 and rd_addr steps 1..5.
  - rd_count goes 5,4,3,2,1,0.
  - ALMOST_EMPTY rises when rd_count=2; EMPTY rises after the 5th pop.
  - A 6th R_INC does not move the pointer.
- EMPTY=1, single R_INC pulse -> rd_ptr unchanged, UNDERFLOW=1 and held for 10 cycles.
  - ERR_CLR together with R_INC -> UNDERFLOW stays 1.
  - ERR_CLR alone -> UNDERFLOW=0 next cycle.
- Wrap with rd_ptr=14 and w2r_ptr=0011 (bin 2):
  - rd_count=4.
  - Pops give gray_rd_ptr 1000 (15), then 0000 (0), and rd_addr 6→7→0.
  - 4 pops total leave EMPTY=1.
- Full-depth case, rd_ptr=0 and w2r_ptr=1100 (bin 8) -> rd_count=8, EMPTY=0, ALMOST_EMPTY=0.
- Mid-operation reset with rd_ptr=6, R_INC=1, R_RST=1 for one cycle -> next cycle rd_ptr=0, gray_rd_ptr=0000, UNDERFLOW=0.
